// File: rtl/rtc_pkg.sv
// Shared types, BCD range limits and the BCD validation helper for the RTC.
package rtc_pkg;
  typedef logic [3:0] bcd_t;
  typedef logic [7:0] bcd2_t;

  localparam bcd2_t MAX_SS = 8'h59;
  localparam bcd2_t MAX_MM = 8'h59;
  localparam bcd2_t MAX_HH = 8'h23;

  // Both nibbles must be decimal digits; once they are, packed BCD compares numerically.
  function automatic logic bcd_valid(input bcd2_t v, input bcd2_t max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction
endpackage

// File: rtl/bcd7seg.sv
// BCD digit to 7-segment decoder, {dp,g,f,e,d,c,b,a} active-high, dp unused.
module bcd7seg
  import rtc_pkg::*;
(
  input  bcd_t       digit_i,
  output logic [7:0] seg_o
);
  // Fixed lookup; non-decimal codes blank the digit.
  always_comb begin
    seg_o = 8'h00;
    case (digit_i)
      4'd0: seg_o = 8'h3F;
      4'd1: seg_o = 8'h06;
      4'd2: seg_o = 8'h5B;
      4'd3: seg_o = 8'h4F;
      4'd4: seg_o = 8'h66;
      4'd5: seg_o = 8'h6D;
      4'd6: seg_o = 8'h7D;
      4'd7: seg_o = 8'h07;
      4'd8: seg_o = 8'h7F;
      4'd9: seg_o = 8'h6F;
      default: seg_o = 8'h00;
    endcase
  end
endmodule

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD mod-MOD counter with load (priority over inc) and carry-out on wrap.
module bcd_digit_pair
  import rtc_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  inc_i,
  input  logic  load_i,
  input  bcd2_t load_val_i,
  output bcd2_t val_o,
  output bcd2_t nxt_o,
  output logic  carry_o
);
  localparam bcd_t MAX_HI = bcd_t'((MOD - 1) / 10);
  localparam bcd_t MAX_LO = bcd_t'((MOD - 1) % 10);

  bcd2_t val_q, val_d, inc_val;
  logic  wrap_w;

  assign wrap_w  = (val_q == {MAX_HI, MAX_LO});
  assign carry_o = inc_i && wrap_w;
  assign val_o   = val_q;
  // Next value is exposed so the parent can match the post-tick time in the tick cycle.
  assign nxt_o   = val_d;

  // Next-state: wrap to 00, carry units into tens, or bump units.
  always_comb begin
    if (wrap_w)                 inc_val = 8'h00;
    else if (val_q[3:0] == 4'd9) inc_val = {val_q[7:4] + 4'd1, 4'd0};
    else                        inc_val = {val_q[7:4], val_q[3:0] + 4'd1};
    val_d = val_q;
    if (load_i)     val_d = load_val_i;
    else if (inc_i) val_d = inc_val;
  end

  // Digit register.
  always_ff @(posedge clk_i) begin
    if (rst_i) val_q <= 8'h00;
    else       val_q <= val_d;
  end
endmodule

// File: rtl/bcd_rtc_clock.sv
// hh:mm:ss BCD real-time clock: prescaler, settable time, alarm, 12/24h display, 7-seg out.
module bcd_rtc_clock
  import rtc_pkg::*;
#(
  parameter int CLK_DIV    = 500,
  parameter int ALARM_SECS = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        mode_12h,
  input  logic        set_en,
  input  logic [7:0]  set_hh,
  input  logic [7:0]  set_mm,
  input  logic [7:0]  set_ss,
  output logic        set_err,
  input  logic        alarm_load,
  input  logic        alarm_arm,
  input  logic        alarm_ack,
  output logic        alarm_ring,
  output logic        sec_tick,
  output logic        day_tick,
  output logic        pm,
  output logic [23:0] time_bcd,
  output logic [47:0] seg_out
);
  localparam int             PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  PRE_MAX   = PW'(CLK_DIV - 1);
  localparam logic [7:0]     RING_LAST = 8'(ALARM_SECS);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_w, set_ok_w, alm_ok_w, inc_ss, trig_w;
  logic          ss_cy, mm_cy, hh_cy;
  bcd2_t         ss_w, mm_w, hh_w, ss_nxt, mm_nxt, hh_nxt;
  bcd2_t         alm_hh_q, alm_mm_q, disp_hh;
  logic          sec_tick_q, day_tick_q, set_err_q, ring_q;
  logic [7:0]    rcnt_q;
  logic [4:0]    hbin, hdisp;
  logic [5:0][7:0] seg_w;

  assign tick_w   = en && (pre_q == PRE_MAX);
  assign set_ok_w = set_en && bcd_valid(set_hh, MAX_HH) && bcd_valid(set_mm, MAX_MM)
                    && bcd_valid(set_ss, MAX_SS);
  assign alm_ok_w = alarm_load && bcd_valid(set_hh, MAX_HH) && bcd_valid(set_mm, MAX_MM);
  // A valid set overrides the increment; an invalid set leaves the tick untouched.
  assign inc_ss   = tick_w && !set_ok_w;
  // Only tick-driven arrivals at alarm_hh:alarm_mm:00 fire the alarm.
  assign trig_w   = inc_ss && alarm_arm && ({hh_nxt, mm_nxt, ss_nxt} == {alm_hh_q, alm_mm_q, 8'h00});

  bcd_digit_pair #(.MOD(60)) u_ss (
    .clk_i(clk), .rst_i(reset), .inc_i(inc_ss), .load_i(set_ok_w), .load_val_i(set_ss),
    .val_o(ss_w), .nxt_o(ss_nxt), .carry_o(ss_cy));
  bcd_digit_pair #(.MOD(60)) u_mm (
    .clk_i(clk), .rst_i(reset), .inc_i(ss_cy), .load_i(set_ok_w), .load_val_i(set_mm),
    .val_o(mm_w), .nxt_o(mm_nxt), .carry_o(mm_cy));
  bcd_digit_pair #(.MOD(24)) u_hh (
    .clk_i(clk), .rst_i(reset), .inc_i(mm_cy), .load_i(set_ok_w), .load_val_i(set_hh),
    .val_o(hh_w), .nxt_o(hh_nxt), .carry_o(hh_cy));

  // Prescaler next state: valid set restarts the second, en=0 freezes it.
  always_comb begin
    pre_d = pre_q;
    if (set_ok_w)    pre_d = '0;
    else if (tick_w) pre_d = '0;
    else if (en)     pre_d = pre_q + PW'(1);
  end

  // Prescaler and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sec_tick_q <= tick_w;
      day_tick_q <= hh_cy;
      set_err_q  <= (set_en && !set_ok_w) || (alarm_load && !alm_ok_w);
    end
  end

  // Alarm time register.
  always_ff @(posedge clk) begin
    if (reset) begin
      alm_hh_q <= 8'h00;
      alm_mm_q <= 8'h00;
    end else if (alm_ok_w) begin
      alm_hh_q <= set_hh;
      alm_mm_q <= set_mm;
    end
  end

  // Ring: set on match, dropped by ack, disarm, or ALARM_SECS further ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      ring_q <= 1'b0;
      rcnt_q <= 8'd0;
    end else if (trig_w) begin
      ring_q <= 1'b1;
      rcnt_q <= 8'd0;
    end else if (ring_q) begin
      if (alarm_ack || !alarm_arm) begin
        ring_q <= 1'b0;
      end else if (tick_w) begin
        if (rcnt_q + 8'd1 == RING_LAST) ring_q <= 1'b0;
        rcnt_q <= rcnt_q + 8'd1;
      end
    end
  end

  // 12h remap of the hour: 00->12, 13..23->01..11; internal time stays 24h.
  always_comb begin
    hbin  = 5'(hh_w[7:4]) * 5'd10 + 5'(hh_w[3:0]);
    hdisp = hbin;
    if (hbin == 5'd0)       hdisp = 5'd12;
    else if (hbin > 5'd12)  hdisp = hbin - 5'd12;
    if (hdisp >= 5'd10) disp_hh = {4'd1, 4'(hdisp - 5'd10)};
    else                disp_hh = {4'd0, 4'(hdisp)};
  end

  assign time_bcd   = {(mode_12h ? disp_hh : hh_w), mm_w, ss_w};
  assign pm         = (hh_w >= 8'h12);
  assign sec_tick   = sec_tick_q;
  assign day_tick   = day_tick_q;
  assign set_err    = set_err_q;
  assign alarm_ring = ring_q;
  assign seg_out    = seg_w;

  for (genvar i = 0; i < 6; i++) begin : g_seg
    bcd7seg u_dec (.digit_i(time_bcd[4*i +: 4]), .seg_o(seg_w[i]));
  end
endmodule

// File: tb/tb_bcd_rtc_clock.sv
// Directed bench for bcd_rtc_clock with CLK_DIV=4, ALARM_SECS=3.
module tb_bcd_rtc_clock;
  logic        clk = 1'b0;
  logic        reset, en, mode_12h, set_en, alarm_load, alarm_arm, alarm_ack;
  logic [7:0]  set_hh, set_mm, set_ss;
  logic        set_err, alarm_ring, sec_tick, day_tick, pm;
  logic [23:0] time_bcd;
  logic [47:0] seg_out;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  bcd_rtc_clock #(.CLK_DIV(4), .ALARM_SECS(3)) dut (
    .clk(clk), .reset(reset), .en(en), .mode_12h(mode_12h),
    .set_en(set_en), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .set_err(set_err), .alarm_load(alarm_load), .alarm_arm(alarm_arm),
    .alarm_ack(alarm_ack), .alarm_ring(alarm_ring), .sec_tick(sec_tick),
    .day_tick(day_tick), .pm(pm), .time_bcd(time_bcd), .seg_out(seg_out));

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hh = h; set_mm = m; set_ss = s; set_en = 1'b1;
    step(1);
    set_en = 1'b0;
  endtask

  task automatic do_alm(input logic [7:0] h, input logic [7:0] m);
    set_hh = h; set_mm = m; set_ss = 8'h00; alarm_load = 1'b1;
    step(1);
    alarm_load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 100000", $time);
    $fatal(1);
  end

  initial begin
    int nt, nd;
    reset = 1'b1; en = 1'b0; mode_12h = 1'b0; set_en = 1'b0; alarm_load = 1'b0;
    alarm_arm = 1'b0; alarm_ack = 1'b0; set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
    step(2);
    chk("rst_time", 48'(time_bcd), 48'h000000);
    chk("rst_flags", 48'({sec_tick, day_tick, set_err, alarm_ring, pm}), 48'h0);
    chk("rst_seg", seg_out, 48'h3F3F3F3F3F3F);

    // free run: 40 clocks = 10 seconds
    reset = 1'b0; en = 1'b1; nt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (sec_tick) nt++;
    end
    chk("tick_count", 48'(nt), 48'd10);
    chk("run_time", 48'(time_bcd), 48'h000010);
    chk("run_seg", seg_out, 48'h3F3F3F3F063F);
    chk("run_pm", 48'(pm), 48'h0);

    // day rollover
    do_set(8'h23, 8'h59, 8'h58);
    chk("set_time", 48'(time_bcd), 48'h235958);
    chk("set_pm", 48'(pm), 48'h1);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (day_tick) begin
        nd++;
        chk("day_wrap_time", 48'(time_bcd), 48'h000000);
      end
      if (i == 3) chk("pre_wrap_time", 48'(time_bcd), 48'h235959);
    end
    chk("day_count", 48'(nd), 48'd1);
    chk("post_wrap_time", 48'(time_bcd), 48'h000000);

    // invalid sets, frozen time
    en = 1'b0;
    do_set(8'h24, 8'h00, 8'h00);
    chk("bad_hh_err", 48'(set_err), 48'h1);
    chk("bad_hh_time", 48'(time_bcd), 48'h000000);
    step(1);
    chk("bad_hh_err_pulse", 48'(set_err), 48'h0);
    do_set(8'h00, 8'h00, 8'h5A);
    chk("bad_ss_err", 48'(set_err), 48'h1);
    chk("bad_ss_time", 48'(time_bcd), 48'h000000);
    step(1);
    chk("bad_ss_err_pulse", 48'(set_err), 48'h0);
    do_alm(8'h07, 8'h60);
    chk("bad_alm_err", 48'(set_err), 48'h1);
    do_set(8'h12, 8'h34, 8'h56);
    chk("good_set_err", 48'(set_err), 48'h0);
    chk("good_set_time", 48'(time_bcd), 48'h123456);

    // 12h display
    mode_12h = 1'b1;
    do_set(8'h00, 8'h30, 8'h00);
    chk("h12_0030", 48'({pm, time_bcd}), 48'h0123000);
    do_set(8'h12, 8'h00, 8'h00);
    chk("h12_1200", 48'({pm, time_bcd}), 48'h1120000);
    do_set(8'h13, 8'h05, 8'h00);
    chk("h12_1305", 48'({pm, time_bcd}), 48'h1010500);
    chk("h12_seg", seg_out, 48'h3F063F6D3F3F);
    do_set(8'h22, 8'h00, 8'h00);
    chk("h12_2200", 48'({pm, time_bcd}), 48'h1100000);
    mode_12h = 1'b0;
    #1;
    chk("h24_2200", 48'(time_bcd), 48'h220000);

    // alarm ring, timeout after 3 ticks
    do_alm(8'h07, 8'h00);
    alarm_arm = 1'b1; en = 1'b1;
    do_set(8'h06, 8'h59, 8'h58);
    step(4);
    chk("alm_pre", 48'({alarm_ring, time_bcd}), 48'h0065959);
    step(4);
    chk("alm_on", 48'({alarm_ring, time_bcd}), 48'h1070000);
    step(4);
    chk("alm_s1", 48'({alarm_ring, time_bcd}), 48'h1070001);
    step(4);
    chk("alm_s2", 48'({alarm_ring, time_bcd}), 48'h1070002);
    step(3);
    chk("alm_s2_hold", 48'(alarm_ring), 48'h1);
    step(1);
    chk("alm_off_s3", 48'({alarm_ring, time_bcd}), 48'h0070003);

    // ack drops ring
    do_set(8'h06, 8'h59, 8'h58);
    step(8);
    chk("ack_on", 48'({alarm_ring, time_bcd}), 48'h1070000);
    step(4);
    chk("ack_s1", 48'({alarm_ring, time_bcd}), 48'h1070001);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    chk("ack_off", 48'(alarm_ring), 48'h0);
    step(7);
    chk("ack_stay_off", 48'({alarm_ring, time_bcd}), 48'h0070003);

    // disarm drops ring
    do_set(8'h06, 8'h59, 8'h58);
    step(8);
    chk("arm_on", 48'(alarm_ring), 48'h1);
    alarm_arm = 1'b0;
    step(1);
    chk("disarm_off", 48'(alarm_ring), 48'h0);
    alarm_arm = 1'b1;

    // loading the alarm time directly does not fire
    do_set(8'h07, 8'h00, 8'h00);
    chk("set_match_noring", 48'(alarm_ring), 48'h0);
    step(4);
    chk("set_match_after", 48'({alarm_ring, time_bcd}), 48'h0070001);

    // reset mid-ring together with a set
    do_set(8'h06, 8'h59, 8'h58);
    step(8);
    chk("rst_ring_on", 48'(alarm_ring), 48'h1);
    reset = 1'b1; set_hh = 8'h12; set_mm = 8'h34; set_ss = 8'h56; set_en = 1'b1;
    step(1);
    set_en = 1'b0;
    chk("rst2_time", 48'(time_bcd), 48'h000000);
    chk("rst2_flags", 48'({sec_tick, day_tick, set_err, alarm_ring, pm}), 48'h0);

    // set coinciding with a tick: set wins, tick still pulses
    reset = 1'b0;
    step(3);
    chk("coinc_pre_tick", 48'(sec_tick), 48'h0);
    do_set(8'h10, 8'h10, 8'h10);
    chk("coinc_time", 48'({sec_tick, time_bcd}), 48'h1101010);
    step(4);
    chk("coinc_next", 48'({sec_tick, time_bcd}), 48'h1101011);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
